// File: rtl/uart_tx_parity_if.sv
// Transmit request/status bundle between the channel-processor logic and the UART transmitter.
interface uart_tx_parity_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       Tx;
  logic       busy;
  logic       done;

  modport master (output tx_start, output tx_data, input Tx, input busy, input done);
  modport slave  (input tx_start, input tx_data, output Tx, output busy, output done);
endinterface

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop; one byte per accepted request.
// Tx, busy and done are all registered, so the serial line is glitch-free.
module uart_tx_parity #(
  parameter int CLKS_PER_BIT = 32,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_parity_if.slave  bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (bus.tx_start && !busy_q) begin
          state_d = S_START;
          shift_d = bus.tx_data;
          par_d   = PARITY_ODD ? ~^bus.tx_data : ^bus.tx_data;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            // next bit is driven straight from bit 1 so Tx changes on the boundary edge
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Scoreboard bench for uart_tx_parity: a request model pushes expected frames, a line monitor
// reassembles frames from Tx at mid-bit and checks them together with busy/done timing.
module tb_uart_tx_parity;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_parity_if bus ();
  uart_tx_parity_if bus_odd ();

  uart_tx_parity #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  uart_tx_parity #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b1)) dut_odd (
    .clk (clk),
    .rst (rst),
    .bus (bus_odd.slave)
  );

  int tests = 0;
  int fails = 0;
  int viol = 0;
  int rem = 0;
  int accepts = 0;
  int cyc = 0;
  int cnt = 0;
  bit in_frame = 1'b0;
  logic [10:0] bits;
  logic [10:0] exp_q[$];
  int done_times[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame as seen on the wire, index 0 = start bit.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit odd);
    int ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = ((ones % 2) == 1) ^ odd;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Request model: a request is taken when none is outstanding; a frame occupies 11N cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem = 0;
      exp_q.delete();
    end else if (rem > 0) begin
      rem = rem - 1;
    end else if (bus.tx_start) begin
      exp_q.push_back(mk_frame(bus.tx_data, 1'b0));
      rem = 11 * N;
      accepts++;
    end
  end

  always @(negedge clk) begin
    logic [10:0] e;
    cyc++;
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && bus.busy) begin
        in_frame = 1'b1;
        cnt = 0;
        bits = '0;
      end
      if (in_frame) begin
        if (bus.busy) begin
          if (bus.done !== 1'b0) viol++;
          if ((cnt % N) == N / 2 && (cnt / N) < 11) bits[cnt / N] = bus.Tx;
          cnt++;
        end else begin
          chk("busy_len", cnt, 11 * N);
          chk("done_pulse", {31'd0, bus.done}, 1);
          chk("tx_idle_after", {31'd0, bus.Tx}, 1);
          chk("frame_expected", {31'd0, exp_q.size() > 0}, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame", {21'd0, bits}, {21'd0, e});
          end
          done_times.push_back(cyc);
          in_frame = 1'b0;
        end
      end else if (bus.Tx !== 1'b1 || bus.done !== 1'b0) begin
        viol++;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.tx_start = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((rem != 0 || in_frame) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle_bound", {31'd0, k < 2000}, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_accepts(input int target);
    int k = 0;
    while (accepts < target && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("accept_bound", {31'd0, k < 1000}, 1);
  endtask

  initial begin
    int d0;
    logic [10:0] fo;
    bus.tx_start = 1'b0;
    bus.tx_data = 8'h00;
    bus_odd.tx_start = 1'b0;
    bus_odd.tx_data = 8'h00;

    #150;
    chk("reset_tx", {31'd0, bus.Tx}, 1);
    chk("reset_busy", {31'd0, bus.busy}, 0);
    chk("reset_done", {31'd0, bus.done}, 0);
    #150;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_busy", {31'd0, bus.busy}, 0);

    send(8'h21);
    wait_idle();

    // 0x2F on both the even and the odd instance at once
    @(negedge clk);
    bus.tx_start = 1'b1; bus.tx_data = 8'h2F;
    bus_odd.tx_start = 1'b1; bus_odd.tx_data = 8'h2F;
    @(negedge clk);
    bus.tx_start = 1'b0; bus_odd.tx_start = 1'b0;
    fo = mk_frame(8'h2F, 1'b1);
    repeat (N / 2) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      chk("odd_bit", {31'd0, bus_odd.Tx}, {31'd0, fo[k]});
      if (k == 9) chk("odd_parity", {31'd0, bus_odd.Tx}, 0);
      if (k < 10) repeat (N) @(negedge clk);
    end
    wait_idle();

    // request while busy is dropped; data changes mid-frame are ignored
    send(8'h21);
    repeat (100) @(negedge clk);
    bus.tx_start = 1'b1; bus.tx_data = 8'h55;
    @(negedge clk);
    bus.tx_start = 1'b0;
    repeat (100) @(negedge clk);
    bus.tx_data = 8'($urandom);
    wait_idle();
    repeat (400) @(negedge clk);

    // back-to-back with tx_start held high
    d0 = done_times.size();
    @(negedge clk);
    bus.tx_start = 1'b1; bus.tx_data = 8'hFF;
    wait_accepts(accepts + 1);
    bus.tx_data = 8'h00;
    wait_accepts(accepts + 1);
    bus.tx_start = 1'b0;
    wait_idle();
    chk("b2b_done_count", done_times.size(), d0 + 2);
    if (done_times.size() >= d0 + 2)
      chk("b2b_done_gap", done_times[d0 + 1] - done_times[d0], 11 * N + 1);

    // reset during data bit 3
    send(8'hA5);
    repeat (4 * N + 5) @(negedge clk);
    d0 = done_times.size();
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", {31'd0, bus.Tx}, 1);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_no_done", done_times.size(), d0);
    send(8'h3C);
    wait_idle();

    // random traffic, including requests while busy and back-to-back acceptance
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      bus.tx_start = ($urandom_range(0, 63) == 0);
      bus.tx_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.tx_start = 1'b0;
    wait_idle();

    chk("queue_drained", exp_q.size(), 0);
    chk("line_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
